// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared size encodings, sequencer states and lane helpers for the
//            dmem controller.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Replace the addressed byte/half lane of old_word with right-justified wdata.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic [1:0]  off
    );
        logic [31:0] w_res;
        w_res = old_word;
        case (size)
            SZ_B:    w_res[{off, 3'b000} +: 8]     = wdata[7:0];
            SZ_H:    w_res[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default: w_res = wdata;
        endcase
        return w_res;
    endfunction

    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  off,
        input logic        uns
    );
        logic [7:0]  w_b;
        logic [15:0] w_h;
        logic [31:0] w_res;
        w_b = word[{off, 3'b000} +: 8];
        w_h = word[{off[1], 4'b0000} +: 16];
        case (size)
            SZ_B:    w_res = {{24{~uns & w_b[7]}}, w_b};
            SZ_H:    w_res = {{16{~uns & w_h[15]}}, w_h};
            default: w_res = word;
        endcase
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : dmem_rr_arb
// Purpose  : Two-way round-robin grant; on a tie the port not granted last wins.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_rr_arb (
    input  logic [1:0] req,
    input  logic       en,
    input  logic       rr_last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ctrl
// Purpose  : Arbitrated access sequencer for the 256 B word-write dmem, with
//            read-modify-write for sub-word stores and extended sub-word loads.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [1:0]        p0_size,
    input  logic              p0_unsigned,
    input  logic [31:0]       p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [1:0]        p1_size,
    input  logic              p1_unsigned,
    input  logic [31:0]       p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_rr_last;
    logic                r_we;
    logic [1:0]          r_size;
    logic                r_uns;
    logic [1:0]          r_off;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_port;
    logic                r_err;
    logic [DATA_W-1:0]   r_rbuf;
    logic [31:0]         r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic [1:0]          w_gnt;
    logic                w_any;
    logic                w_sel;
    logic                w_req_we;
    logic [1:0]          w_req_size;
    logic                w_req_uns;
    logic [31:0]         w_req_addr;
    logic [DATA_W-1:0]   w_req_wdata;
    logic                w_err;
    logic [DATA_W-1:0]   w_ld_data;

    // Grants are suppressed while reset is held so nothing is accepted then.
    dmem_rr_arb u_arb (
        .req     ({p1_req, p0_req}),
        .en      ((r_state == ST_IDLE) && rst),
        .rr_last (r_rr_last),
        .gnt     (w_gnt)
    );

    assign w_any       = |w_gnt;
    assign w_sel       = w_gnt[1];
    assign w_req_we    = w_sel ? p1_we       : p0_we;
    assign w_req_size  = w_sel ? p1_size     : p0_size;
    assign w_req_uns   = w_sel ? p1_unsigned : p0_unsigned;
    assign w_req_addr  = w_sel ? p1_addr     : p0_addr;
    assign w_req_wdata = w_sel ? p1_wdata    : p0_wdata;

    assign w_err = (w_req_size == SZ_RSV)
                || ((w_req_size == SZ_H) && w_req_addr[0])
                || ((w_req_size == SZ_W) && (w_req_addr[1:0] != 2'b00))
                || (|w_req_addr[31:ADDR_W]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    if (w_err)                      w_state_nxt = ST_RESP;
                    else if (!w_req_we)             w_state_nxt = ST_RD;
                    else if (w_req_size == SZ_W)    w_state_nxt = ST_WR;
                    else                            w_state_nxt = ST_RD;
                end
            end
            ST_RD:   w_state_nxt = r_we ? ST_WR : ST_RESP;
            ST_WR:   w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // mem_addr/mem_wdata are registered so they hold between accesses; the
    // merged store word is formed while the RD cycle's read data is present.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_last   <= 1'b1;
            r_we        <= 1'b0;
            r_size      <= SZ_B;
            r_uns       <= 1'b0;
            r_off       <= 2'b00;
            r_wdata     <= '0;
            r_port      <= 1'b0;
            r_err       <= 1'b0;
            r_rbuf      <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (w_any) begin
                r_rr_last <= w_sel;
                r_port    <= w_sel;
                r_we      <= w_req_we;
                r_size    <= w_req_size;
                r_uns     <= w_req_uns;
                r_off     <= w_req_addr[1:0];
                r_wdata   <= w_req_wdata;
                r_err     <= w_err;
                if (!w_err) begin
                    r_mem_addr <= {w_req_addr[31:2], 2'b00};
                    if (w_req_we && (w_req_size == SZ_W)) begin
                        r_mem_wdata <= w_req_wdata;
                    end
                end
            end
            if (r_state == ST_RD) begin
                r_rbuf <= mem_rdata;
                if (r_we) begin
                    r_mem_wdata <= lane_merge(mem_rdata, r_wdata, r_size, r_off);
                end
            end
        end
    end

    always_comb begin
        p0_gnt    = w_gnt[0];
        p1_gnt    = w_gnt[1];
        p0_rvalid = 1'b0;
        p1_rvalid = 1'b0;
        p0_err    = 1'b0;
        p1_err    = 1'b0;
        p0_rdata  = '0;
        p1_rdata  = '0;
        w_ld_data = (r_we || r_err) ? '0 : load_extend(r_rbuf, r_size, r_off, r_uns);
        if (r_state == ST_RESP) begin
            if (r_port) begin
                p1_rvalid = 1'b1;
                p1_err    = r_err;
                p1_rdata  = w_ld_data;
            end else begin
                p0_rvalid = 1'b1;
                p0_err    = r_err;
                p0_rdata  = w_ld_data;
            end
        end
        mem_we    = (r_state == ST_WR);
        mem_addr  = r_mem_addr;
        mem_wdata = r_mem_wdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_ctrl
// Purpose  : Directed bench for dmem_ctrl with a transaction-level memory model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        p0_req, p0_we, p0_unsigned, p0_gnt, p0_rvalid, p0_err;
    logic [1:0]  p0_size;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_unsigned, p1_gnt, p1_rvalid, p1_err;
    logic [1:0]  p1_size;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [7:0]  dmem [256] = '{default: 8'h00};
    logic [7:0]  refm [256] = '{default: 8'h00};

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
        int          due;
        logic        wr;
        logic [31:0] addr;
        int          nb;
        logic [31:0] wdata;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          free_cyc = 0;
    int          exp_we_cyc = -1;
    logic [31:0] exp_we_addr, exp_we_data;
    logic        m_last = 1'b1;
    logic [31:0] last_rdata [2];
    logic        last_err [2];
    int          glog [6] = '{default: 9};

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_unsigned(p0_unsigned),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
        .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_unsigned(p1_unsigned),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
        .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = {dmem[{mem_addr[7:2], 2'd3}], dmem[{mem_addr[7:2], 2'd2}],
                        dmem[{mem_addr[7:2], 2'd1}], dmem[{mem_addr[7:2], 2'd0}]};

    always @(posedge clk) begin
        if (mem_we) begin
            dmem[{mem_addr[7:2], 2'd0}] <= mem_wdata[7:0];
            dmem[{mem_addr[7:2], 2'd1}] <= mem_wdata[15:8];
            dmem[{mem_addr[7:2], 2'd2}] <= mem_wdata[23:16];
            dmem[{mem_addr[7:2], 2'd3}] <= mem_wdata[31:24];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: byte memory and access rules --------
    function automatic logic m_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
            || (a >= 32'd256);
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
        int nb;
        logic [31:0] v;
        nb = 1 << sz;
        v = 32'd0;
        for (int i = 0; i < nb; i++) v = v | (32'(refm[a + 32'(i)]) << (8 * i));
        if (!uns && nb < 4 && v[8 * nb - 1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        return v;
    endfunction

    function automatic logic [31:0] m_merge(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int nb;
        int base;
        logic [31:0] w;
        nb = 1 << sz;
        base = int'(a) - int'(a % 4);
        w = 32'd0;
        for (int i = 0; i < 4; i++) w[8 * i +: 8] = refm[base + i];
        for (int i = 0; i < nb; i++) w[8 * (int'(a % 4) + i) +: 8] = wd[8 * i +: 8];
        return w;
    endfunction

    task automatic compare_loop();
        exp_t        e;
        logic [1:0]  rv, exp_g;
        logic        m_we, m_uns;
        logic [1:0]  m_sz;
        logic [31:0] m_a, m_wd, rd;
        logic        er;
        int          p, lat;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                q.delete();
                exp_we_cyc = -1;
                free_cyc   = 0;
                m_last     = 1'b1;
            end else begin
                rv = {p1_rvalid, p0_rvalid};
                for (int k = 0; k < 2; k++) begin
                    if (rv[k]) begin
                        rd = (k == 0) ? p0_rdata : p1_rdata;
                        er = (k == 0) ? p0_err   : p1_err;
                        if (q.size() == 0) begin
                            check("rvalid_unexpected", 32'(rv), 32'd0);
                        end else begin
                            e = q.pop_front();
                            check("resp_port", 32'(k), 32'(e.port));
                            check("resp_err", 32'(er), 32'(e.err));
                            check("resp_rdata", rd, e.rdata);
                            check("resp_cycle", 32'(cyc), 32'(e.due));
                            if (e.wr)
                                for (int i = 0; i < e.nb; i++) refm[e.addr + 32'(i)] = e.wdata[8 * i +: 8];
                            last_rdata[k] = rd;
                            last_err[k]   = er;
                        end
                    end
                end
                if (q.size() > 0 && cyc > q[0].due) begin
                    check("rvalid_missing_cycle", 32'(cyc), 32'(q[0].due));
                    void'(q.pop_front());
                end
                check("mem_we", 32'(mem_we), 32'(cyc == exp_we_cyc));
                if (mem_we && cyc == exp_we_cyc) begin
                    check("mem_addr", mem_addr, exp_we_addr);
                    check("mem_wdata", mem_wdata, exp_we_data);
                end
                exp_g = 2'b00;
                if (cyc >= free_cyc) begin
                    if (p0_req && p1_req) exp_g = m_last ? 2'b01 : 2'b10;
                    else                  exp_g = {p1_req, p0_req};
                end
                check("gnt", 32'({p1_gnt, p0_gnt}), 32'(exp_g));
                if (exp_g != 2'b00) begin
                    p     = exp_g[0] ? 0 : 1;
                    m_we  = (p == 0) ? p0_we       : p1_we;
                    m_sz  = (p == 0) ? p0_size     : p1_size;
                    m_uns = (p == 0) ? p0_unsigned : p1_unsigned;
                    m_a   = (p == 0) ? p0_addr     : p1_addr;
                    m_wd  = (p == 0) ? p0_wdata    : p1_wdata;
                    e.port  = p;
                    e.err   = m_err(m_sz, m_a);
                    e.wr    = m_we && !e.err;
                    e.addr  = m_a;
                    e.nb    = 1 << m_sz;
                    e.wdata = m_wd;
                    e.rdata = (m_we || e.err) ? 32'd0 : m_load(m_sz, m_uns, m_a);
                    lat = e.err ? 1 : (!m_we ? 2 : ((m_sz == 2'd2) ? 2 : 3));
                    e.due = cyc + lat;
                    q.push_back(e);
                    m_last   = (p == 1);
                    free_cyc = cyc + lat + 1;
                    if (e.wr) begin
                        exp_we_cyc  = cyc + lat - 1;
                        exp_we_addr = m_a & 32'hFFFF_FFFC;
                        exp_we_data = (m_sz == 2'd2) ? m_wd : m_merge(m_sz, m_a, m_wd);
                    end
                end
            end
        end
    endtask

    // ---------------- stimulus ----------------------------------------------
    task automatic issue(input int p, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        logic got;
        if (p == 0) begin
            p0_we = we; p0_size = sz; p0_unsigned = uns; p0_addr = a; p0_wdata = wd; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_size = sz; p1_unsigned = uns; p1_addr = a; p1_wdata = wd; p1_req = 1'b1;
        end
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            got = (p == 0) ? p0_gnt : p1_gnt;
        end
        check("gnt_seen", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        if (p == 0) p0_req = 1'b0; else p1_req = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (q.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("resp_drained", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic access(input int p, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd);
        issue(p, we, sz, uns, a, wd);
        wait_done();
    endtask

    initial begin
        int n0, n1, k, guard, nbad;
        p0_req = 1'b0; p0_we = 1'b0; p0_size = 2'b10; p0_unsigned = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_size = 2'b10; p1_unsigned = 1'b0; p1_addr = '0; p1_wdata = '0;
        last_rdata[0] = '0; last_rdata[1] = '0; last_err[0] = 1'b0; last_err[1] = 1'b0;
        fork
            compare_loop();
        join_none

        // Reset state, with a request pending that must not be granted.
        p0_req = 1'b1;
        #2;
        check("rst_gnt", 32'({p1_gnt, p0_gnt}), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_rvalid", 32'({p1_rvalid, p0_rvalid, p1_err, p0_err}), 32'd0);
        check("rst_rdata", p0_rdata | p1_rdata, 32'd0);
        p0_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Word store then load.
        access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("t1_lw_rdata", last_rdata[0], 32'hDEADBEEF);
        check("t1_lw_err", 32'(last_err[0]), 32'd0);

        // Byte store RMW, then word / signed / unsigned byte loads.
        access(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
        access(0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA);
        access(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        check("t2_lw", last_rdata[0], 32'h1122AA44);
        access(0, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
        check("t2_lb", last_rdata[0], 32'hFFFFFFAA);
        access(0, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
        check("t2_lbu", last_rdata[0], 32'h000000AA);
        access(1, 1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
        check("t2_p1_lh", last_rdata[1], 32'hFFFFAA44);

        // Both ports requesting continuously.
        p0_we = 1'b0; p0_size = 2'b10; p0_addr = 32'h10;
        p1_we = 1'b0; p1_size = 2'b10; p1_addr = 32'h20;
        p0_req = 1'b1; p1_req = 1'b1;
        n0 = 3; n1 = 3; k = 0; guard = 0;
        while ((n0 > 0 || n1 > 0) && guard < 100) begin
            @(negedge clk);
            guard++;
            if (p0_gnt && k < 6) begin glog[k] = 0; k++; n0--; end
            if (p1_gnt && k < 6) begin glog[k] = 1; k++; n1--; end
            @(posedge clk);
            #1;
            if (n0 <= 0) p0_req = 1'b0;
            if (n1 <= 0) p1_req = 1'b0;
        end
        p0_req = 1'b0; p1_req = 1'b0;
        check("t3_grants_left", 32'(n0 + n1), 32'd0);
        for (int i = 0; i < 6; i++) check($sformatf("t3_order%0d", i), 32'(glog[i]), 32'(i % 2));
        wait_done();

        // Error cases.
        last_err[0] = 1'b0;
        access(0, 1'b0, 2'b01, 1'b0, 32'h23, 32'h0);
        check("t4_lh_mis_err", 32'(last_err[0]), 32'd1);
        last_err[0] = 1'b0;
        access(0, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
        check("t4_lw_mis_err", 32'(last_err[0]), 32'd1);
        last_err[0] = 1'b0;
        access(0, 1'b1, 2'b11, 1'b0, 32'h24, 32'hCAFEF00D);
        check("t4_rsv_err", 32'(last_err[0]), 32'd1);
        last_err[0] = 1'b0;
        access(0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hCAFEF00D);
        check("t4_oor_err", 32'(last_err[0]), 32'd1);
        check("t4_oor_rdata", last_rdata[0], 32'd0);

        // Reset in the WR cycle of a half store.
        access(0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h55667788);
        issue(0, 1'b1, 2'b01, 1'b0, 32'h32, 32'h00001234);
        @(posedge clk);
        #1;
        check("t5_we_in_wr", 32'(mem_we), 32'd1);
        rst = 1'b0;
        #1;
        check("t5_we_drop", 32'(mem_we), 32'd0);
        check("t5_addr_rst", mem_addr, 32'd0);
        check("t5_wdata_rst", mem_wdata, 32'd0);
        check("t5_rvalid_rst", 32'({p1_rvalid, p0_rvalid}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        access(0, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
        check("t5_word_kept", last_rdata[0], 32'h55667788);

        // Top-of-memory half access.
        access(1, 1'b1, 2'b01, 1'b0, 32'hFE, 32'h0000BEEF);
        access(1, 1'b0, 2'b01, 1'b1, 32'hFE, 32'h0);
        check("t6_lhu_top", last_rdata[1], 32'h0000BEEF);
        access(1, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
        check("t6_no_wrap", last_rdata[1], 32'h00000000);

        nbad = 0;
        for (int i = 0; i < 256; i++) if (dmem[i] !== refm[i]) nbad++;
        check("mem_final_bad_bytes", 32'(nbad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
